// File: rtl/clk_div_meter_pkg.sv
// clk_div_meter_pkg: shared state encoding and saturating-count helper for clk_div_meter
package clk_div_meter_pkg;
    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;
    function automatic int unsigned sat_inc(int unsigned v, int unsigned lim);
        return (v >= lim) ? lim : v + 1;
    endfunction
endpackage

// File: rtl/clk_div_edge_det.sv
// clk_div_edge_det: registers the divided clock and flags its rising and falling edges
module clk_div_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic div_q;
    always_ff @(posedge clk) begin
        if (!reset) div_q <= 1'b0;
        else        div_q <= d;
    end
    assign rise = d & ~div_q;
    assign fall = ~d & div_q;
endmodule

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period/high time of a synchronous divided clock, tracks lock and timeout
module clk_div_meter
    import clk_div_meter_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAX_PERIOD = 255,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned EXP_PERIOD = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_vld,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);
    localparam int unsigned M_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MAXV  = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] EXPV  = CNT_W'(EXP_PERIOD);
    localparam logic [M_W-1:0]   LOCKM = M_W'(LOCK_CNT);

    logic rise, fall, active, inc;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
    logic [M_W-1:0] match_q, match_d;
    logic vld_q, vld_d, mis_q, mis_d, timeout_q, timeout_d, first_q, first_d;

    clk_div_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (div_in),
        .rise  (rise),
        .fall  (fall)
    );

    assign active = (state_q != IDLE);
    assign inc    = div_in & ~fall;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        first_d   = first_q;
        timeout_d = timeout_q;
        vld_d     = 1'b0;
        mis_d     = 1'b0;
        if (rise) begin
            cnt_d     = CNT_W'(1);
            hcnt_d    = CNT_W'(1);
            timeout_d = 1'b0;
            if (!active) begin
                state_d = MEAS;
                first_d = 1'b1;
                match_d = '0;
            end else begin
                period_d = cnt_q;
                high_d   = hcnt_q;
                vld_d    = 1'b1;
                mis_d    = (EXP_PERIOD != 0) && (cnt_q != EXPV);
                // the first capture after arming has no previous period to compare against
                match_d  = (!first_q && cnt_q == period_q) ? M_W'(sat_inc(32'(match_q), LOCK_CNT)) : '0;
                first_d  = 1'b0;
                state_d  = (match_d == LOCKM) ? LOCK : MEAS;
            end
        end else if (active) begin
            cnt_d  = CNT_W'(sat_inc(32'(cnt_q), MAX_PERIOD));
            hcnt_d = inc ? CNT_W'(sat_inc(32'(hcnt_q), MAX_PERIOD)) : hcnt_q;
            if (cnt_q == MAXV) begin
                timeout_d = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= '0;
            first_q   <= 1'b0;
            timeout_q <= 1'b0;
            vld_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
            vld_q     <= vld_d;
            mis_q     <= mis_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign period_vld = vld_q;
    assign mismatch   = mis_q;
    assign timeout    = timeout_q;
    assign locked     = (state_q == LOCK);
endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: directed stimulus with a scoreboard queue checked on every period_vld
module tb_clk_div_meter;
    logic clk, reset, div_in;
    logic [7:0] period, high_time;
    logic period_vld, locked, mismatch, timeout;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int p;
        int h;
        int m;
        int lk;
    } exp_t;
    exp_t q[$];

    clk_div_meter dut (
        .clk        (clk),
        .reset      (reset),
        .div_in     (div_in),
        .period     (period),
        .high_time  (high_time),
        .period_vld (period_vld),
        .locked     (locked),
        .mismatch   (mismatch),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one div_in period starting with a rise; v says whether that rise must produce period_vld
    task automatic prd(input int h, input int l, input bit v, input int ep, input int eh, input int em, input int el);
        if (v) q.push_back('{ep, eh, em, el});
        div_in = 1'b1;
        repeat (h) tick();
        div_in = 1'b0;
        repeat (l) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_vld"}, int'(period_vld), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_mismatch"}, int'(mismatch), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            if (period_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_vld_period", int'(period), -1);
                end else begin
                    e = q.pop_front();
                    chk("vld_period", int'(period), e.p);
                    chk("vld_high_time", int'(high_time), e.h);
                    chk("vld_mismatch", int'(mismatch), e.m);
                    chk("vld_locked", int'(locked), e.lk);
                end
            end else begin
                chk("mismatch_without_vld", int'(mismatch), 0);
            end
        end
    end

    initial begin
        reset  = 1'b0;
        div_in = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b1;
        // divide-by-12, lock at the 5th rise
        prd(6, 6, 0, 0, 0, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 1);
        chk("locked_after_r5", int'(locked), 1);
        prd(6, 6, 1, 12, 6, 0, 1);
        // switch to divide-by-10, then back to 12
        prd(5, 5, 1, 12, 6, 0, 1);
        prd(5, 5, 1, 10, 5, 1, 0);
        prd(5, 5, 1, 10, 5, 1, 0);
        prd(5, 5, 1, 10, 5, 1, 0);
        prd(6, 6, 1, 10, 5, 1, 1);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 1);
        prd(6, 6, 1, 12, 6, 0, 1);
        // freeze low after one more locked rise
        q.push_back('{12, 6, 0, 1});
        div_in = 1'b1;
        tick();
        repeat (5) tick();
        div_in = 1'b0;
        repeat (249) tick();
        chk("timeout_before", int'(timeout), 0);
        chk("locked_before_timeout", int'(locked), 1);
        tick();
        chk("timeout_set", int'(timeout), 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_period_hold", int'(period), 12);
        chk("timeout_high_hold", int'(high_time), 6);
        repeat (3) tick();
        chk("timeout_sticky", int'(timeout), 1);
        // restart: first rise clears timeout and only arms
        div_in = 1'b1;
        tick();
        chk("timeout_cleared", int'(timeout), 0);
        chk("rearm_locked", int'(locked), 0);
        repeat (5) tick();
        div_in = 1'b0;
        repeat (6) tick();
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 0);
        prd(6, 6, 1, 12, 6, 0, 1);
        // reset mid-period while locked
        q.push_back('{12, 6, 0, 1});
        div_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk_zero("midreset");
        tick();
        reset = 1'b1;
        prd(3, 6, 0, 0, 0, 0, 0);
        prd(6, 6, 1, 9, 3, 1, 0);
        // fastest toggle, then a period of exactly MAX_PERIOD
        prd(1, 1, 1, 12, 6, 0, 0);
        prd(1, 1, 1, 2, 1, 1, 0);
        prd(1, 1, 1, 2, 1, 1, 0);
        prd(1, 1, 1, 2, 1, 1, 0);
        prd(1, 254, 1, 2, 1, 1, 1);
        chk("max_period_no_timeout", int'(timeout), 0);
        prd(1, 5, 1, 255, 1, 1, 0);
        chk("after_max_timeout", int'(timeout), 0);
        repeat (4) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
